fp_mul_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier for the shader ALU. It generalises our combinational single-precision multiplier in several ways:
- configurable exponent and mantissa widths;
- three-stage pipeline with a valid/ready handshake;
- round-to-nearest-even;
- IEEE special-value handling (Inf, NaN, signed zero);
- a sideband tag carried alongside each operation.

Subnormals are flushed to zero on both inputs and outputs.

---
 rtl/fp_mul_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - three-stage pipelined FP multiplier with RNE, specials, DAZ/FTZ and tag sideband; optional FP_MUL_FLAGS_EN adds out_flags
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
`ifdef FP_MUL_FLAGS_EN
    output logic [3:0]               out_flags,
`endif
    output logic [TAG_W-1:0]         out_tag
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;
    localparam logic [EW2-1:0] BIAS_E = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0] EMAX_E = EW2'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    // stage registers
    logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic               sign1_q, sign1_d, sign2_q, sign2_d;
    logic [EW2-1:0]     exp1_q, exp1_d, exp2_q, exp2_d;
    logic [MAN_W-1:0]   fa1_q, fa1_d, fb1_q, fb1_d;
    cls_t               cls1_q, cls1_d, cls2_q, cls2_d;
    logic [TAG_W-1:0]   tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
    logic [PW-1:0]      prod2_q, prod2_d;
    logic [W-1:0]       res3_q, res3_d;
`ifdef FP_MUL_FLAGS_EN
    logic               inv1_q, inv1_d, inv2_q, inv2_d;
    logic [3:0]         flags3_q, flags3_d;
    logic [3:0]         flags_n;
    logic               a_snan, b_snan;
`endif

    // handshake: each stage may load when empty or when its successor advances
    logic rdy2, rdy3;
    assign rdy3     = !v3_q || out_ready;
    assign rdy2     = !v2_q || rdy3;
    assign in_ready = !v1_q || rdy2;

    assign out_valid  = v3_q;
    assign out_result = res3_q;
    assign out_tag    = tag3_q;
`ifdef FP_MUL_FLAGS_EN
    assign out_flags  = flags3_q;
`endif

    // S1 operand decode: field split, zero/Inf/NaN classification, exponent sum
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    cls_t             cls_in;
    logic [EW2-1:0]   esum;

    always_comb begin
        ea     = in_a[MAN_W +: EXP_W];
        eb     = in_b[MAN_W +: EXP_W];
        fa     = in_a[MAN_W-1:0];
        fb     = in_b[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (&ea) && (fa == '0);
        b_inf  = (&eb) && (fb == '0);
        a_nan  = (&ea) && (fa != '0);
        b_nan  = (&eb) && (fb != '0);
        esum   = EW2'(ea) + EW2'(eb) - BIAS_E;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            cls_in = CLS_NAN;
        end else if (a_inf || b_inf) begin
            cls_in = CLS_INF;
        end else if (a_zero || b_zero) begin
            cls_in = CLS_ZERO;
        end else begin
            cls_in = CLS_NORM;
        end
`ifdef FP_MUL_FLAGS_EN
        a_snan = a_nan && !fa[MAN_W-1];
        b_snan = b_nan && !fb[MAN_W-1];
`endif
    end

    // S3 normalise, round-to-nearest-even and pack from the registered product
    logic               msb, guard, sticky, rnd, carry, ovf, unf;
    logic [PW-2:0]      sh;
    logic [MAN_W-1:0]   frac, frac_r;
    logic [EW2-1:0]     e_n, e_r;
    logic [W-1:0]       res_n;

    always_comb begin
        msb             = prod2_q[PW-1];
        sh              = msb ? prod2_q[PW-2:0] : {prod2_q[PW-3:0], 1'b0};
        frac            = sh[PW-2 -: MAN_W];
        guard           = sh[MAN_W];
        sticky          = |sh[MAN_W-1:0];
        rnd             = guard && (sticky || frac[0]);
        {carry, frac_r} = {1'b0, frac} + (MAN_W+1)'(rnd);
        e_n             = exp2_q + EW2'(msb);
        e_r             = e_n + EW2'(carry);
        ovf             = ($signed(e_r) >= $signed(EMAX_E));
        unf             = ($signed(e_r) <= $signed(EW2'(0)));
        case (cls2_q)
            CLS_NAN:  res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            CLS_INF:  res_n = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_ZERO: res_n = {sign2_q, {(EXP_W+MAN_W){1'b0}}};
            default: begin
                if (ovf) begin
                    res_n = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (unf) begin
                    res_n = {sign2_q, {(EXP_W+MAN_W){1'b0}}};
                end else begin
                    res_n = {sign2_q, e_r[EXP_W-1:0], frac_r};
                end
            end
        endcase
`ifdef FP_MUL_FLAGS_EN
        flags_n[3] = inv2_q;
        flags_n[2] = (cls2_q == CLS_NORM) && ovf;
        flags_n[1] = (cls2_q == CLS_NORM) && !ovf && unf;
        flags_n[0] = (cls2_q == CLS_NORM) && (guard || sticky || ovf || unf);
`endif
    end

    // next-state for all three stages; a stage's data only moves when it loads a valid op
    always_comb begin
        v1_d    = v1_q;    v2_d    = v2_q;    v3_d   = v3_q;
        sign1_d = sign1_q; sign2_d = sign2_q;
        exp1_d  = exp1_q;  exp2_d  = exp2_q;
        fa1_d   = fa1_q;   fb1_d   = fb1_q;
        cls1_d  = cls1_q;  cls2_d  = cls2_q;
        tag1_d  = tag1_q;  tag2_d  = tag2_q;  tag3_d = tag3_q;
        prod2_d = prod2_q; res3_d  = res3_q;
`ifdef FP_MUL_FLAGS_EN
        inv1_d   = inv1_q;
        inv2_d   = inv2_q;
        flags3_d = flags3_q;
`endif
        if (in_ready) begin
            v1_d = in_valid;
            if (in_valid) begin
                sign1_d = in_a[W-1] ^ in_b[W-1];
                exp1_d  = esum;
                fa1_d   = fa;
                fb1_d   = fb;
                cls1_d  = cls_in;
                tag1_d  = in_tag;
`ifdef FP_MUL_FLAGS_EN
                inv1_d  = a_snan || b_snan || (a_inf && b_zero) || (b_inf && a_zero);
`endif
            end
        end
        if (rdy2) begin
            v2_d = v1_q;
            if (v1_q) begin
                sign2_d = sign1_q;
                exp2_d  = exp1_q;
                cls2_d  = cls1_q;
                tag2_d  = tag1_q;
                prod2_d = PW'({1'b1, fa1_q}) * PW'({1'b1, fb1_q});
`ifdef FP_MUL_FLAGS_EN
                inv2_d  = inv1_q;
`endif
            end
        end
        if (rdy3) begin
            v3_d = v2_q;
            if (v2_q) begin
                res3_d = res_n;
                tag3_d = tag2_q;
`ifdef FP_MUL_FLAGS_EN
                flags3_d = flags_n;
`endif
            end
        end
    end

    // pipeline state; asynchronous reset drops every in-flight op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;  v2_q    <= 1'b0;  v3_q   <= 1'b0;
            sign1_q <= 1'b0;  sign2_q <= 1'b0;
            exp1_q  <= '0;    exp2_q  <= '0;
            fa1_q   <= '0;    fb1_q   <= '0;
            cls1_q  <= CLS_NORM;
            cls2_q  <= CLS_NORM;
            tag1_q  <= '0;    tag2_q  <= '0;    tag3_q <= '0;
            prod2_q <= '0;    res3_q  <= '0;
`ifdef FP_MUL_FLAGS_EN
            inv1_q   <= 1'b0;
            inv2_q   <= 1'b0;
            flags3_q <= '0;
`endif
        end else begin
            v1_q    <= v1_d;    v2_q    <= v2_d;    v3_q   <= v3_d;
            sign1_q <= sign1_d; sign2_q <= sign2_d;
            exp1_q  <= exp1_d;  exp2_q  <= exp2_d;
            fa1_q   <= fa1_d;   fb1_q   <= fb1_d;
            cls1_q  <= cls1_d;  cls2_q  <= cls2_d;
            tag1_q  <= tag1_d;  tag2_q  <= tag2_d;  tag3_q <= tag3_d;
            prod2_q <= prod2_d; res3_q  <= res3_d;
`ifdef FP_MUL_FLAGS_EN
            inv1_q   <= inv1_d;
            inv2_q   <= inv2_d;
            flags3_q <= flags3_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - scoreboard bench for fp_mul_pipe (single precision, FP_MUL_FLAGS_EN aware)
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [3:0]  in_tag, out_tag;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
`ifdef FP_MUL_FLAGS_EN
        .out_flags  (out_flags),
`endif
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [3:0]  flg;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  n_acc = 0;
    int  acc_edge = 0;

    // operand table: a, b, expected product, expected {invalid, overflow, underflow, inexact}
    logic [31:0] va [13];
    logic [31:0] vb [13];
    logic [31:0] vr [13];
    logic [3:0]  vf [13];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // output side: every transfer pops the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("extra_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", out_result, mon_e.res);
                chk("tag", {28'd0, out_tag}, {28'd0, mon_e.tag});
`ifdef FP_MUL_FLAGS_EN
                chk("flags", {28'd0, out_flags}, {28'd0, mon_e.flg});
`endif
            end
        end
    end

    // present one operand pair until accepted; called just after a rising edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                        input logic [31:0] r, input logic [3:0] f);
        sb_t x;
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        in_a = a;
        in_b = b;
        in_tag = t;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                x.res = r;
                x.tag = t;
                x.flg = f;
                sb.push_back(x);
                acc_edge = cyc + 1;
                n_acc++;
                done = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    chk("accept_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    // edges from the accepting edge (counted as 1) to the edge after which out_valid is seen
    task automatic check_latency(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk(tag, cyc - acc_edge + 1, 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    logic [31:0] hold_r;
    logic [3:0]  hold_t;
    logic [31:0] bx;

    initial begin
        va = '{32'h40400000, 32'hBFC00000, 32'h3F800001, 32'h7F800000, 32'h7FC00000,
               32'hFF800000, 32'h7F7FFFFF, 32'h00800000, 32'h00000001, 32'h7F800001,
               32'h80000000, 32'h3F800001, 32'h40400000};
        vb = '{32'h40000000, 32'h40000000, 32'h3F800001, 32'h00000000, 32'h3F800000,
               32'h40000000, 32'h40000000, 32'h3F000000, 32'h7F000000, 32'h3F800000,
               32'h3F800000, 32'h3FC00000, 32'h40400000};
        vr = '{32'h40C00000, 32'hC0400000, 32'h3F800002, 32'h7FC00000, 32'h7FC00000,
               32'hFF800000, 32'h7F800000, 32'h00000000, 32'h00000000, 32'h7FC00000,
               32'h80000000, 32'h3FC00002, 32'h41100000};
        vf = '{4'h0, 4'h0, 4'h1, 4'h8, 4'h0,
               4'h0, 4'h5, 4'h3, 4'h0, 4'h8,
               4'h0, 4'h1, 4'h0};

        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single op: latency and tag echo
        send(32'h40400000, 32'h40000000, 4'hA, 32'h40C00000, 4'h0);
        check_latency("latency_first");
        drain();

        // operand table back to back
        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            send(va[i], vb[i], 4'(i), vr[i], vf[i]);
        end
        drain();

        // 1.5 x (1 + 3 ulp) is an exact half-ulp tie with even lsb: stays down
        @(posedge clk);
        #1;
        send(32'h3F800003, 32'h3FC00000, 4'hD, 32'h3FC00004, 4'h1);
        drain();

        // backpressure: eight ops tagged 0..7 against a six-cycle stall
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    bx = {1'b0, 8'(128 + i), 23'h0};
                    send(32'h3F800000, bx, 4'(i), bx, 4'h0);
                end
            end
        join_none
        repeat (4) @(negedge clk);
        #1;
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_head_tag", {28'd0, out_tag}, 32'd0);
        hold_r = out_result;
        hold_t = out_tag;
        repeat (2) @(negedge clk);
        #1;
        chk("stall_result_held", out_result, hold_r);
        chk("stall_tag_held", {28'd0, out_tag}, {28'd0, hold_t});
        chk("stall_accepted", n_acc, 32'd3);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (n_acc < 8 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("bp_all_accepted", n_acc, 32'd8);
        drain();

        // asynchronous reset with three ops in flight
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            send(va[i], vb[i], 4'(i), vr[i], vf[i]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_result", out_result, 32'd0);
        chk("arst_out_tag", {28'd0, out_tag}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(32'hBFC00000, 32'h40000000, 4'h6, 32'hC0400000, 4'h0);
        check_latency("latency_after_reset");
        drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
